// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, controller state encoding and command field extraction
// for the ALU command controller.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_LOADI = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    // Extracts a w-bit field starting at bit lsb; callers cast to their field width.
    function automatic logic [31:0] cmd_field(input logic [63:0] cmd,
                                              input int unsigned lsb,
                                              input int unsigned w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 32'((cmd >> lsb) & mask);
    endfunction

endpackage

// File: rtl/alu_cmd_controller_if.sv
// Command and ALU handshake bundle; the controller uses the slave modport, the
// command source / ALU side uses the master modport.
interface alu_cmd_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 3
);
    localparam int CMD_W = OP_W + 3 * ADDR_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd;
    logic              alu_valid;
    logic              alu_ready;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;

    modport master (
        output cmd_valid, cmd, alu_ready, res_valid, res_data,
        input  cmd_ready, alu_valid, alu_op, alu_a, alu_b
    );

    modport slave (
        input  cmd_valid, cmd, alu_ready, res_valid, res_data,
        output cmd_ready, alu_valid, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_cmd_controller_regfile.sv
// Register file: one synchronous write port, three combinational read ports,
// every entry cleared by the asynchronous reset.
module ctrl_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    input  logic [ADDR_W-1:0] i_raddr3,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic [DATA_W-1:0] o_rdata3
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
    assign o_rdata3 = r_mem[i_raddr3];
endmodule

// File: rtl/alu_cmd_controller.sv
// Command controller: decodes packed commands, issues register operands to the ALU
// and writes results (or load-immediates) back; HALT is sticky until reset.
module alu_cmd_controller
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_cmd_controller_if.slave   bus,
    output logic                  busy,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int CMD_W = OP_W + 3 * ADDR_W;

    ctrl_state_t       r_state;
    logic              r_cmd_ready;
    logic              r_alu_valid;
    logic              r_busy;
    logic              r_halted;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_instr_count;

    logic [63:0]       w_cmd64;
    logic [OP_W-1:0]   w_op;
    logic [ADDR_W-1:0] w_src1;
    logic [ADDR_W-1:0] w_src2;
    logic [ADDR_W-1:0] w_dst;
    logic              w_accept;
    logic              w_is_loadi;
    logic              w_is_halt;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_cmd64 = 64'(bus.cmd);
    assign w_op    = OP_W'(cmd_field(w_cmd64, 3 * ADDR_W, OP_W));
    assign w_src1  = ADDR_W'(cmd_field(w_cmd64, 2 * ADDR_W, ADDR_W));
    assign w_src2  = ADDR_W'(cmd_field(w_cmd64, ADDR_W, ADDR_W));
    assign w_dst   = ADDR_W'(cmd_field(w_cmd64, 0, ADDR_W));

    assign w_accept   = (r_state == ST_IDLE) && bus.cmd_valid && r_cmd_ready;
    assign w_is_loadi = (w_op == OP_W'(OP_LOADI));
    assign w_is_halt  = (w_op == OP_W'(OP_HALT));

    // LOADI writes at the accept edge; ALU results write at the end of WAIT.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_dst;
        w_wdata = DATA_W'({w_src1, w_src2});
        if (w_accept && w_is_loadi) begin
            w_we = 1'b1;
        end else if (r_state == ST_WAIT && bus.res_valid) begin
            w_we    = 1'b1;
            w_waddr = r_dst;
            w_wdata = bus.res_data;
        end
    end

    ctrl_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr1 (w_src1),
        .i_raddr2 (w_src2),
        .i_raddr3 (dbg_addr),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2),
        .o_rdata3 (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_alu_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_dst         <= '0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_halt) begin
                            r_state       <= ST_HALTED;
                            r_cmd_ready   <= 1'b0;
                            r_halted      <= 1'b1;
                            r_instr_count <= r_instr_count + CNT_W'(1);
                        end else if (w_is_loadi) begin
                            r_instr_count <= r_instr_count + CNT_W'(1);
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_cmd_ready <= 1'b0;
                            r_alu_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_op        <= w_op;
                            r_a         <= w_rd1;
                            r_b         <= w_rd2;
                            r_dst       <= w_dst;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.alu_ready) begin
                        r_state     <= ST_WAIT;
                        r_alu_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.res_valid) begin
                        r_state       <= ST_IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_instr_count <= r_instr_count + CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_alu_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.alu_valid = r_alu_valid;
    assign bus.alu_op    = r_op;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign busy          = r_busy;
    assign halted        = r_halted;
    assign instr_count   = r_instr_count;
endmodule

// File: tb/tb_alu_cmd_controller.sv
// Directed bench for alu_cmd_controller: LOADI, stalled and best-case ALU issue,
// aliasing, spurious handshakes, HALT and mid-operation reset.
module tb_alu_cmd_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    alu_cmd_controller_if bus ();

    alu_cmd_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic [2:0] d);
        return {op, s1, s2, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd = '0; bus.alu_ready = 1'b0;
        bus.res_valid = 1'b0; bus.res_data = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.alu_valid, busy, halted} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl got rdy/vld/busy/halt=%b want 1000",
                               {bus.cmd_ready, bus.alu_valid, busy, halted});
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, instr_count} !== '0) begin
            errors++; $display("FAIL reset_data got op=%0h a=%0h b=%0h cnt=%0d want all 0",
                               bus.alu_op, bus.alu_a, bus.alu_b, instr_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loadi;
        bus.cmd_valid = 1'b1;
        bus.cmd = 12'b110_000_101_001;
        tick();
        checks++;
        if ({bus.cmd_ready, busy, bus.alu_valid} !== 3'b100) begin
            errors++; $display("FAIL loadi_ready got rdy/busy/vld=%b want 100",
                               {bus.cmd_ready, busy, bus.alu_valid});
        end
        bus.cmd = mk(3'b110, 3'd0, 3'd3, 3'd2);
        tick();
        bus.cmd = mk(3'b110, 3'd7, 3'd7, 3'd4);
        tick();
        bus.cmd_valid = 1'b0;
        read_reg(3'd1, rv);
        checks++;
        if (rv !== 32'd5) begin errors++; $display("FAIL loadi_r1 got %0h want 5", rv); end
        read_reg(3'd2, rv);
        checks++;
        if (rv !== 32'd3) begin errors++; $display("FAIL loadi_r2 got %0h want 3", rv); end
        read_reg(3'd4, rv);
        checks++;
        if (rv !== 32'd63) begin errors++; $display("FAIL loadi_r4_max got %0h want 3f", rv); end
        checks++;
        if (instr_count !== 16'd3) begin
            errors++; $display("FAIL loadi_count got %0d want 3", instr_count);
        end
    endtask

    task automatic test_alu_stall;
        bus.alu_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd = mk(3'b000, 3'd1, 3'd2, 3'd3);
        tick();
        // A pending LOADI r3 during the stall must not be taken.
        bus.cmd = mk(3'b110, 3'd0, 3'd1, 3'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.alu_valid, bus.cmd_ready, busy} !== 3'b101) begin
                errors++; $display("FAIL stall_ctrl%0d got vld/rdy/busy=%b want 101", i,
                                   {bus.alu_valid, bus.cmd_ready, busy});
            end
            checks++;
            if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3 || bus.alu_op !== 3'd0) begin
                errors++; $display("FAIL stall_ops%0d got op=%0h a=%0h b=%0h want 0 5 3", i,
                                   bus.alu_op, bus.alu_a, bus.alu_b);
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        checks++;
        if ({bus.alu_valid, bus.cmd_ready, busy} !== 3'b001) begin
            errors++; $display("FAIL wait_ctrl got vld/rdy/busy=%b want 001",
                               {bus.alu_valid, bus.cmd_ready, busy});
        end
        bus.res_valid = 1'b1;
        bus.res_data = 32'd8;
        tick();
        bus.res_valid = 1'b0;
        read_reg(3'd3, rv);
        checks++;
        if (rv !== 32'd8) begin errors++; $display("FAIL wb_r3 got %0h want 8", rv); end
        checks++;
        if ({bus.cmd_ready, busy} !== 2'b10 || instr_count !== 16'd4) begin
            errors++; $display("FAIL wb_done got rdy/busy=%b cnt=%0d want 10 cnt=4",
                               {bus.cmd_ready, busy}, instr_count);
        end
    endtask

    task automatic test_dst_eq_src;
        bus.cmd_valid = 1'b1;
        bus.cmd = mk(3'b001, 3'd1, 3'd1, 3'd1);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.alu_valid !== 1'b1 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd5 ||
            bus.alu_op !== 3'd1) begin
            errors++; $display("FAIL alias_issue got vld=%b op=%0h a=%0h b=%0h want 1 1 5 5",
                               bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b);
        end
        bus.alu_ready = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data = 32'hFFFF_FFFF;
        tick();
        bus.alu_ready = 1'b0;
        checks++;
        if ({bus.alu_valid, bus.cmd_ready} !== 2'b00 || instr_count !== 16'd4) begin
            errors++; $display("FAIL alias_wait got vld/rdy=%b cnt=%0d want 00 cnt=4",
                               {bus.alu_valid, bus.cmd_ready}, instr_count);
        end
        tick();
        bus.res_valid = 1'b0;
        read_reg(3'd1, rv);
        checks++;
        if (rv !== 32'hFFFF_FFFF || instr_count !== 16'd5 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL alias_wb got r1=%0h cnt=%0d rdy=%b want ffffffff 5 1",
                               rv, instr_count, bus.cmd_ready);
        end
        bus.res_valid = 1'b1;
        bus.res_data = 32'h1234;
        bus.alu_ready = 1'b1;
        repeat (2) tick();
        bus.res_valid = 1'b0;
        bus.alu_ready = 1'b0;
        read_reg(3'd1, rv);
        checks++;
        if (rv !== 32'hFFFF_FFFF) begin errors++; $display("FAIL spur_r1 got %0h want ffffffff", rv); end
        read_reg(3'd3, rv);
        checks++;
        if (rv !== 32'd8) begin errors++; $display("FAIL spur_r3 got %0h want 8", rv); end
        read_reg(3'd0, rv);
        checks++;
        if (rv !== 32'd0 || instr_count !== 16'd5 || bus.alu_valid !== 1'b0) begin
            errors++; $display("FAIL spur_state got r0=%0h cnt=%0d vld=%b want 0 5 0",
                               rv, instr_count, bus.alu_valid);
        end
    endtask

    task automatic test_back_to_back;
        bus.cmd_valid = 1'b1;
        bus.cmd = mk(3'b110, 3'd0, 3'd7, 3'd5);
        tick();
        bus.cmd = mk(3'b010, 3'd5, 3'd2, 3'd6);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.alu_a !== 32'd7 || bus.alu_b !== 32'd3 || bus.alu_op !== 3'd2) begin
            errors++; $display("FAIL b2b_ops got op=%0h a=%0h b=%0h want 2 7 3",
                               bus.alu_op, bus.alu_a, bus.alu_b);
        end
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_data = 32'h55;
        tick();
        bus.res_valid = 1'b0;
        read_reg(3'd6, rv);
        checks++;
        if (rv !== 32'h55 || instr_count !== 16'd7) begin
            errors++; $display("FAIL b2b_wb got r6=%0h cnt=%0d want 55 7", rv, instr_count);
        end
    endtask

    task automatic test_halt;
        bus.cmd_valid = 1'b1;
        bus.cmd = mk(3'b111, 3'd0, 3'd0, 3'd0);
        tick();
        checks++;
        if ({halted, bus.cmd_ready, busy} !== 3'b100 || instr_count !== 16'd8) begin
            errors++; $display("FAIL halt_enter got halt/rdy/busy=%b cnt=%0d want 100 8",
                               {halted, bus.cmd_ready, busy}, instr_count);
        end
        bus.cmd = mk(3'b110, 3'd1, 3'd1, 3'd1);
        repeat (2) tick();
        bus.cmd = mk(3'b000, 3'd1, 3'd2, 3'd3);
        tick();
        bus.cmd_valid = 1'b0;
        read_reg(3'd1, rv);
        checks++;
        if (rv !== 32'hFFFF_FFFF || instr_count !== 16'd8 || halted !== 1'b1 ||
            bus.alu_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL halt_sticky got r1=%0h cnt=%0d halt=%b vld=%b rdy=%b want ffffffff 8 1 0 0",
                               rv, instr_count, halted, bus.alu_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic bad;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL unhalt got halt=%b rdy=%b want 0 1", halted, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd = mk(3'b110, 3'd0, 3'd5, 3'd1);
        tick();
        bus.cmd = mk(3'b000, 3'd1, 3'd1, 3'd2);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if (bus.alu_valid !== 1'b1 || bus.alu_a !== 32'd5) begin
            errors++; $display("FAIL mid_issue got vld=%b a=%0h want 1 5", bus.alu_valid, bus.alu_a);
        end
        bus.res_valid = 1'b1;
        bus.res_data = 32'hAA;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.alu_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_async got vld=%b rdy=%b want 0 1", bus.alu_valid, bus.cmd_ready);
        end
        tick();
        bus.res_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), rv);
            if (rv !== 32'd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || instr_count !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_clear got regs_nonzero=%b cnt=%0d busy=%b want 0 0 0",
                               bad, instr_count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_loadi();
        test_alu_stall();
        test_dst_eq_src();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_controller.md
# alu_cmd_controller

Parametrised command controller: accepts packed commands over a valid/ready handshake, reads two source operands from an internal register file, issues them with an opcode to the ALU over a second handshake, and writes the ALU result back to a destination register. It sits between the command source (testbench or sequencer) and the ALU. Compared with the previous fixed-width controller, it adds a destination writeback path, ALU back-pressure, a load-immediate opcode, a sticky HALT state and a retired-instruction counter.

## Interface
- DATA_W, 32, register/operand/result width
- ADDR_W, 3, register address width; register count NREGS = 2**ADDR_W
- OP_W, 3, opcode width
- CNT_W, 16, retired-instruction counter width
- CMD_W (localparam) = OP_W + 3*ADDR_W (12 at defaults); cmd = {op, src1, src2, dst}, op in the MSBs
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd  in  CMD_W  packed command
- alu_valid  out  1  operands/opcode valid toward the ALU
- alu_ready  in  1  ALU accepts the operation
- alu_op  out  OP_W  opcode to the ALU
- alu_a  out  DATA_W  operand from reg[src1]
- alu_b  out  DATA_W  operand from reg[src2]
- res_valid  in  1  ALU result present
- res_data  in  DATA_W  ALU result
- busy  out  1  high in any state other than IDLE/HALTED
- halted  out  1  HALT has been executed
- instr_count  out  CNT_W  retired commands, wraps modulo 2**CNT_W
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr]

## Operation
- States: IDLE, ISSUE, WAIT, HALTED.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, decode the command:
  - op=3'b111 (HALT): go to HALTED, increment instr_count.
  - op=3'b110 (LOADI): reg[dst] <= zero-extended {src1,src2} (2*ADDR_W bits). Stay in IDLE, increment instr_count. No ALU transaction.
  - Any other op: latch op, reg[src1], reg[src2] and dst into issue registers; go to ISSUE.
- ISSUE: alu_valid=1; alu_op/alu_a/alu_b are held stable until alu_ready. On alu_ready, go to WAIT.
- WAIT: on res_valid, reg[dst] <= res_data, increment instr_count, go to IDLE.
- HALTED: cmd_ready=0 and halted=1 until reset. The command stream is ignored.
- res_valid outside WAIT is ignored. alu_ready outside ISSUE is ignored.
- src1==src2, and dst equal to either source, are legal. Operands are sampled at acceptance.
- Register file: no hardwired zero register; all NREGS registers are writable.

## Timing
- Reset values: every register-file entry 0; state IDLE; cmd_ready=1, alu_valid=0, alu_op=0, alu_a=0, alu_b=0, busy=0, halted=0, instr_count=0.
- cmd_ready is a registered function of state only; it does not depend on cmd_valid combinationally.
- ALU command best case, accepted at edge E0:
  - alu_valid is high in the cycle after E0.
  - If alu_ready is high in that cycle, WAIT is entered at E1.
  - If res_valid is high in the WAIT cycle, the write lands at E2 and cmd_ready is high after E2.
  - Throughput is one ALU command per 3 cycles.
- LOADI: the register write lands at the accept edge. Back-to-back LOADIs run at 1 per cycle. A command accepted the cycle after a LOADI reads the new value.
- No read-after-write hazard: writeback always completes before the next accept.
- Reset asserted mid-operation: alu_valid drops immediately (asynchronously), and all state clears. A pending ALU result is lost.
- instr_count wraps from 2**CNT_W-1 to 0 without a flag.

## Structure
- Shared package alu_ctrl_pkg holds:
  - opcode constants OP_LOADI=3'b110 and OP_HALT=3'b111 (codes 000–101 are ALU-defined and forwarded unchanged);
  - the state enum ctrl_state_t;
  - a command-field extraction function.
- One sub-module, ctrl_regfile: parametrised DATA_W/ADDR_W, asynchronous active-low reset to zero, one synchronous write port, three combinational read ports (src1, src2, debug).

## Test plan
- Reset, then LOADI r1=5 (cmd 12'b110_000_101_001) and LOADI r2=3 -> dbg_data for r1 reads 5 and for r2 reads 3; instr_count=2.
- ADD r1,r2->r3 with alu_ready held low for 4 cycles -> alu_valid stays high with alu_a=5, alu_b=3 stable throughout; cmd_ready=0; busy=1.
- res_valid with res_data=8 in WAIT -> r3 reads 8 on the next cycle; cmd_ready returns high; instr_count=3.
- dst==src1, e.g. op r1,r1->r1 with result 32'hFFFF_FFFF -> r1 reads FFFF_FFFF; spurious res_valid in IDLE leaves the register file unchanged.
- HALT -> halted=1, cmd_ready=0; subsequent cmd_valid pulses leave state and instr_count unchanged.
- rst_n pulsed low while in ISSUE -> alu_valid is low within the same cycle; all registers read 0 and instr_count=0 after release.
